// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue/writeback handshake and status bundle between decode, writeback and the scoreboard
interface reg_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
);
  localparam int IW = $clog2(NREGS);
  localparam int PW = $clog2(NREGS * ((1 << CNT_W) - 1) + 1);
  logic            flush;
  logic            issue_valid;
  logic [IW-1:0]   issue_rs;
  logic [IW-1:0]   issue_rt;
  logic            issue_uses_rs;
  logic            issue_uses_rt;
  logic            issue_wr;
  logic [IW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb_valid;
  logic [IW-1:0]   wb_rd;
  logic [NREGS-1:0] busy_vec;
  logic [PW-1:0]   pending_total;
  logic            err_underflow;
  modport master (
    output flush, issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
           issue_wr, issue_rd, wb_valid, wb_rd,
    input  issue_ready, busy_vec, pending_total, err_underflow
  );
  modport slave (
    input  flush, issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
           issue_wr, issue_rd, wb_valid, wb_rd,
    output issue_ready, busy_vec, pending_total, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write counters that stall issue on RAW hazards or saturated destinations
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst,
  reg_scoreboard_if.slave sb
);
  localparam int IW = $clog2(NREGS);
  localparam int MAX = (1 << CNT_W) - 1;
  localparam int PW = $clog2(NREGS * MAX + 1);
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [PW-1:0] pend_q, pend_d;
  logic err_q, err_d;
  logic [NREGS-1:0] busy;
  logic ready, inc_any, dec_any, under;
  // Register 0 is excluded through the rd!=0 gating, so cnt_q[0] never leaves zero
  always_comb begin
    for (int r = 0; r < NREGS; r++) busy[r] = cnt_q[r] != '0;
    ready = !(sb.issue_uses_rs & busy[sb.issue_rs] & (sb.issue_rs != '0))
          & !(sb.issue_uses_rt & busy[sb.issue_rt] & (sb.issue_rt != '0))
          & !(sb.issue_wr & (sb.issue_rd != '0) & (cnt_q[sb.issue_rd] == CNT_W'(MAX)));
    inc_any = sb.issue_valid & ready & sb.issue_wr & (sb.issue_rd != '0);
    dec_any = sb.wb_valid & (sb.wb_rd != '0) & (cnt_q[sb.wb_rd] != '0);
    under = sb.wb_valid & (sb.wb_rd != '0) & (cnt_q[sb.wb_rd] == '0);
    for (int r = 0; r < NREGS; r++)
      cnt_d[r] = sb.flush ? '0 : cnt_q[r] + CNT_W'(inc_any && sb.issue_rd == IW'(r))
                                          - CNT_W'(dec_any && sb.wb_rd == IW'(r));
    pend_d = sb.flush ? '0 : pend_q + PW'(inc_any) - PW'(dec_any);
    err_d = err_q | (under & !sb.flush);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '{default: '0};
      pend_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  assign sb.issue_ready = ready;
  assign sb.busy_vec = busy;
  assign sb.pending_total = pend_q;
  assign sb.err_underflow = err_q;
endmodule
